// File: rtl/grid_display_tx.sv
`default_nettype none
// ============================================================================
// Module      : grid_display_tx
// Description : Serialises a 64-bit Game-of-Life grid snapshot, row by row, to
//               an external MAX7219-style 8x8 LED-matrix driver. Each row is
//               one 16-bit word (address byte = row+1, data byte = row bits,
//               column 7 first), shifted MSB first on sclk and loaded with a
//               latch strobe.
//               Row timing (D = CLK_DIV):
//                 16 bit slots of 2D cycles (sclk low D, high D)
//                 1 settle slot of 2D cycles (sclk held low, sdata held)
//                 latch high for D cycles, then a D-cycle gap
//               giving 36D cycles per row and 288D cycles per frame.
//               The end of the last gap returns straight to IDLE, where a
//               registered frame_done pulse marks the frame boundary.
// Options     : `define AUTO_REFRESH_EN to retransmit the held snapshot
//               whenever no new grid is offered at a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_display_tx #(
    parameter int CLK_DIV = 4,
    parameter int ROWS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic        sclk,
    output logic        sdata,
    output logic        latch,
    output logic        busy,
    output logic        frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]       c_ROW_LAST = 3'(ROWS - 1);
    // Slot index 16 is the settle slot after the last data bit.
    localparam logic [4:0]       c_BIT_TAIL = 5'd16;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic             r_half;      // 0: sclk-low half of slot, 1: high half
    logic [4:0]       r_bit;
    logic [2:0]       r_row;
    logic [63:0]      r_snap;
    logic             r_frame_done;

    logic             w_div_end;
    logic             w_accept;
    logic             w_start;
    logic             w_frame_end;
    logic [7:0]       w_addr;
    logic [15:0]      w_word;

    assign w_div_end   = (r_div == c_DIV_LAST);
    assign w_accept    = (r_state == c_ST_IDLE) && grid_valid;
    assign w_frame_end = (r_state == c_ST_GAP) && w_div_end && (r_row == c_ROW_LAST);

`ifdef AUTO_REFRESH_EN
    // Every IDLE cycle starts a frame: new grid if offered, else the held one.
    assign w_start = (r_state == c_ST_IDLE);
`else
    // A frame starts only when a new grid is handed over.
    assign w_start = w_accept;
`endif

    assign w_addr = {5'd0, r_row} + 8'd1;
    assign w_word = {w_addr, r_snap[{r_row, 3'b000} +: 8]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; every non-idle transition happens at a divider wrap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_div_end && r_half && (r_bit == c_BIT_TAIL)) begin
                    w_state_nxt = c_ST_LATCH;
                end
            end
            c_ST_LATCH: begin
                if (w_div_end) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (w_div_end) begin
                    w_state_nxt = (r_row == c_ROW_LAST) ? c_ST_IDLE : c_ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from state and counters.
    always_comb begin
        grid_ready = (r_state == c_ST_IDLE);
        busy       = (r_state != c_ST_IDLE);
        latch      = (r_state == c_ST_LATCH);
        frame_done = r_frame_done;
        sclk       = 1'b0;
        sdata      = 1'b0;
        if (r_state == c_ST_SHIFT) begin
            if (r_bit == c_BIT_TAIL) begin
                // Settle slot: sclk stays low, last bit held for driver hold time.
                sdata = w_word[0];
            end else begin
                sclk  = r_half;
                sdata = w_word[4'd15 - r_bit[3:0]];
            end
        end
    end

    // Divider and half-period phase; both rest at zero in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_half <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            r_div  <= '0;
            r_half <= 1'b0;
        end else begin
            r_div <= w_div_end ? '0 : r_div + 1'b1;
            if ((r_state == c_ST_SHIFT) && w_div_end) begin
                r_half <= ~r_half;
            end
        end
    end

    // Bit-slot and row counters, cleared explicitly at row and frame ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit <= '0;
            r_row <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_bit <= '0;
            r_row <= '0;
        end else begin
            if ((r_state == c_ST_SHIFT) && w_div_end && r_half) begin
                r_bit <= (r_bit == c_BIT_TAIL) ? 5'd0 : r_bit + 5'd1;
            end
            if ((r_state == c_ST_GAP) && w_div_end) begin
                r_row <= (r_row == c_ROW_LAST) ? 3'd0 : r_row + 3'd1;
            end
        end
    end

    // Snapshot capture on handshake; upstream may change grid_in afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= '0;
        end else if (w_accept) begin
            r_snap <= grid_in;
        end
    end

    // One-cycle frame_done, coincident with the first IDLE cycle after a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_display_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_display_tx
// Description : Scoreboard bench for grid_display_tx. A model process turns
//               every frame start into expected row words, latch times and a
//               frame_done time; a monitor decodes the serial lines and
//               compares. Build with AUTO_REFRESH_EN to exercise refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_display_tx;

    localparam int D = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] grid_in = '0;
    logic        grid_valid = 1'b0;
    logic        grid_ready, sclk, sdata, latch, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] wq[$];
    int          wt[$];
    int          dq[$];

    grid_display_tx #(.CLK_DIV(D), .ROWS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .grid_in    (grid_in),
        .grid_valid (grid_valid),
        .grid_ready (grid_ready),
        .sclk       (sclk),
        .sdata      (sdata),
        .latch      (latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [63:0] held = '0;
    bit          exp_busy_next = 0;
    bit          start_now;

    task automatic push_frame(input logic [63:0] g, input int c);
        for (int r = 0; r < 8; r++) begin
            wq.push_back({8'(r + 1), 8'((g >> (8 * r)) & 64'hFF)});
            wt.push_back(c + 1 + 36 * D * (r + 1) - 2 * D);
        end
        dq.push_back(c + 1 + 288 * D);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            wq.delete(); wt.delete(); dq.delete();
            held = '0;
            exp_busy_next = 0;
        end else begin
            if (exp_busy_next) begin
                checks++;
                if (!(busy === 1'b1 && grid_ready === 1'b0)) begin
                    errors++;
                    $display("FAIL start_busy cyc %0d got busy=%b ready=%b want busy=1 ready=0", cyc, busy, grid_ready);
                end
            end
            exp_busy_next = 0;
            if (grid_ready === 1'b1) begin
                start_now = 0;
                if (grid_valid) begin
                    held = grid_in;
                    start_now = 1;
                end
`ifdef AUTO_REFRESH_EN
                else start_now = 1;
`endif
                if (start_now) begin
                    push_frame(held, cyc);
                    exp_busy_next = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          psclk = 0, platch = 0;
    logic [15:0] acc = '0;
    int          nbits = 0, llen = 0, et;
    logic        hbit = 1'b0;
    logic [15:0] ew;

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (sclk | sdata | latch | busy | frame_done | !grid_ready) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got sclk=%b sdata=%b latch=%b busy=%b done=%b ready=%b want 0 0 0 0 0 1",
                         cyc, sclk, sdata, latch, busy, frame_done, grid_ready);
            end
            acc = '0; nbits = 0; psclk = 0; platch = 0; llen = 0;
        end else begin
            if (sclk && !psclk) begin
                acc = {acc[14:0], sdata};
                nbits++;
                hbit = sdata;
            end else if (sclk && psclk) begin
                checks++;
                if (sdata !== hbit) begin
                    errors++;
                    $display("FAIL sdata_hold cyc %0d got %b want %b", cyc, sdata, hbit);
                end
            end
            if (latch && !platch) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_latch cyc %0d got latch=1 want none", cyc);
                end else begin
                    ew = wq.pop_front();
                    et = wt.pop_front();
                    if (acc !== ew || nbits != 16 || cyc != et) begin
                        errors++;
                        $display("FAIL row_word got %h (%0d bits) at cyc %0d want %h (16 bits) at cyc %0d",
                                 acc, nbits, cyc, ew, et);
                    end
                end
                acc = '0; nbits = 0; llen = 1;
            end else if (latch) begin
                llen++;
            end else if (platch) begin
                checks++;
                if (llen != D) begin
                    errors++;
                    $display("FAIL latch_width got %0d want %0d", llen, D);
                end
            end
            if (latch) begin
                checks++;
                if (sclk !== 1'b0 || sdata !== 1'b0) begin
                    errors++;
                    $display("FAIL latch_lines cyc %0d got sclk=%b sdata=%b want 0 0", cyc, sclk, sdata);
                end
            end
            if (!busy) begin
                checks++;
                if (sclk | sdata | latch) begin
                    errors++;
                    $display("FAIL idle_lines cyc %0d got sclk=%b sdata=%b latch=%b want 0 0 0", cyc, sclk, sdata, latch);
                end
            end
            if (frame_done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc %0d got frame_done=1 want none", cyc);
                end else begin
                    et = dq.pop_front();
                    if (et != cyc || busy !== 1'b0 || grid_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_done got cyc %0d busy=%b ready=%b want cyc %0d busy=0 ready=1",
                                 cyc, busy, grid_ready, et);
                    end
                end
            end
            psclk = sclk;
            platch = latch;
        end
    end

    // ---------------- driver ----------------
    bit last_acc_done = 0;

    task automatic send(input logic [63:0] g, input bit keep, output int acc_cyc);
        bit ok = 0;
        acc_cyc = -1;
        grid_in = g;
        grid_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (grid_ready) begin
                ok = 1;
                acc_cyc = cyc;
                last_acc_done = frame_done;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL handshake_timeout got no ready want ready within 4000 cycles");
        end
        @(posedge clk); #1;
        if (!keep) grid_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done_timeout got no frame_done want one within 3000 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int c1, c2, c3;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
`ifndef AUTO_REFRESH_EN
        // Idle after reset with no valid.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (!grid_ready || busy || sclk || sdata || latch || frame_done) begin
                errors++;
                $display("FAIL post_reset_idle cyc %0d got ready=%b busy=%b sclk=%b sdata=%b latch=%b want 1 0 0 0 0",
                         cyc, grid_ready, busy, sclk, sdata, latch);
            end
        end
        @(posedge clk); #1;

        send(64'h0000_0000_0000_00A5, 0, c1);
        wait_done();

        // Input changes after accept and valid held during busy are ignored.
        send(64'h8100_0000_0000_0081, 1, c1);
        grid_in = '1;
        repeat (500) @(posedge clk);
        #1 grid_valid = 1'b0;
        wait_done();

        // Reset mid-frame abandons the frame immediately.
        send({$urandom, $urandom}, 0, c1);
        while (cyc < c1 + 300) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy || sclk || sdata || latch || !grid_ready) begin
            errors++;
            $display("FAIL async_reset got busy=%b sclk=%b sdata=%b latch=%b ready=%b want 0 0 0 0 1",
                     busy, sclk, sdata, latch, grid_ready);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        send({$urandom, $urandom}, 0, c1);
        wait_done();

        // Back-to-back grids with valid held high.
        send({$urandom, $urandom}, 1, c1);
        grid_in = {$urandom, $urandom};
        send(grid_in, 1, c2);
        checks++;
        if (c2 != c1 + 1 + 288 * D) begin
            errors++;
            $display("FAIL b2b_accept got cyc %0d want cyc %0d", c2, c1 + 1 + 288 * D);
        end
        grid_in = {$urandom, $urandom};
        send(grid_in, 0, c3);
        checks++;
        if (c3 != c2 + 1 + 288 * D) begin
            errors++;
            $display("FAIL b2b_accept got cyc %0d want cyc %0d", c3, c2 + 1 + 288 * D);
        end
        wait_done();

        // Random grids with random idle gaps.
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            send({$urandom, $urandom}, 0, c1);
            wait_done();
        end

        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d words %0d dones pending want 0 0", wq.size(), dq.size());
        end
`else
        // Refresh of the zero snapshot starts right after reset.
        wait_done();
        send(64'hFFFF_FFFF_FFFF_FFFF, 0, c1);
        checks++;
        if (!last_acc_done) begin
            errors++;
            $display("FAIL boundary_accept got cyc %0d off boundary want frame_done cycle", c1);
        end
        repeat (3) wait_done();
        send(64'h0, 0, c2);
        checks++;
        if (!last_acc_done || (c2 - c1) % (1 + 288 * D) != 0) begin
            errors++;
            $display("FAIL boundary_accept got cyc %0d want multiple of %0d after %0d", c2, 1 + 288 * D, c1);
        end
        repeat (2) wait_done();
        do_reset(3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
